inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Instruction fetch stage directly upstream of the instruction register (opcode/field split).
- Owns the program counter and issues one read at a time to program memory.
- Buffers returned words in a 2-entry prefetch FIFO and presents them to the instruction register with a valid/ready handshake.
- Handles branch redirect (flush) and halt.

Parameters:
- INST_LEN, 16, instruction word width; must equal the instruction register input width.
- PC_LEN, 10, program counter / memory address width.
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- clk, input, 1, single clock, rising edge.
- reset, input, 1, synchronous, active-high.
- mem_addr, output, PC_LEN, program memory read address.
- mem_req, output, 1, read request; level-held until mem_ack.
- mem_data, input, INST_LEN, read data; valid when mem_ack=1.
- mem_ack, input, 1, one-cycle read completion.
- branch_en, input, 1, redirect request; one-cycle pulse.
- branch_addr, input, PC_LEN, redirect target.
- halt, input, 1, level; blocks new requests while high.
- inst_out, output, INST_LEN, FIFO head word, fed to the instruction register.
- inst_pc, output, PC_LEN, address of inst_out.
- inst_valid, output, 1, FIFO non-empty.
- inst_ready, input, 1, downstream accepts; pop when inst_valid & inst_ready.

Behaviour:
- Reset values: state=IDLE, pc=RESET_VECTOR, FIFO empty, mem_req=0, mem_addr=RESET_VECTOR, inst_valid=0, inst_out=0, inst_pc=0. Reset overrides every other input on that edge, including mid-request; a mem_ack while in IDLE is ignored.
- States:
  - IDLE: one cycle after reset, then go to FETCH.
  - FETCH: may issue and wait for requests.
  - FLUSH: wait for and discard a stale outstanding ack.
  - HALT: no new issue.
- Issue rule in FETCH:
  - Issue when no request is outstanding, halt=0, and (FIFO count + outstanding) < 2. A same-cycle pop does not free a slot.
  - On issue: mem_req=1, mem_addr=pc; both held stable until mem_ack.
- On mem_ack in FETCH:
  - Push {mem_data, mem_addr} into the FIFO.
  - pc <= pc+1, modulo 2^PC_LEN (wraps to 0).
  - mem_req drops in the same cycle's next edge.
  - A new request may be issued on the cycle after the ack.
- Latency: inst_valid asserts the cycle after mem_ack (minimum). The first request after reset is visible at cycle 2 (reset low at cycle 0, IDLE at cycle 1).
- FIFO:
  - Registered storage; inst_out and inst_pc are driven combinationally from the head entry.
  - Push and pop in the same cycle are allowed at any occupancy.
  - Push when full is impossible by construction; assert in simulation.
  - inst_out holds its last value when empty.
- branch_en=1 (highest priority after reset):
  - FIFO cleared and pc <= branch_addr at the next edge.
  - A pop in the same cycle is void: no instruction is consumed downstream.
  - A mem_ack in the same cycle is dropped.
  - If a request is outstanding and not acked this cycle, go to FLUSH. mem_req stays high with the old address until the ack, then drops.
  - Otherwise go to FETCH; the target request issues the next cycle.
- FLUSH:
  - On mem_ack, discard the data and go to FETCH.
  - A branch_en in FLUSH updates pc again and stays in FLUSH.
- halt=1:
  - From FETCH, go to HALT.
  - An outstanding request still completes and is pushed.
  - The FIFO continues to drain.
  - halt=0 returns to FETCH.
  - branch_en during HALT updates pc and clears the FIFO, remaining in HALT (or FLUSH if a request is outstanding).

Decomposition:
- Shared defines: INST_LEN and PC_LEN values matching the instruction-register widths, and state encodings (IDLE=2'd0, FETCH=2'd1, FLUSH=2'd2, HALT=2'd3).
- One sub-module: fetch_fifo, a 2-entry synchronous FIFO with push, pop, clear, data and count, reset by the same synchronous reset.

Test Plan:
1. Reset, then memory acks each request after 1 cycle with data = 16'hA000+addr, inst_ready=1 → inst_out sequence A000, A001, A002 with inst_pc 0, 1, 2; first inst_valid 2 cycles after the first mem_req.
2. inst_ready=0 for 10 cycles → exactly 2 words buffered, mem_req stays 0 afterward; release → words delivered in order, no loss or duplication.
3. branch_en to branch_addr=10'h3F0 while a request to addr 5 is outstanding, ack 3 cycles later → that ack is discarded; next delivered inst_pc=3F0, FIFO cleared.
4. branch_en and mem_ack in the same cycle, with inst_valid & inst_ready also high → no push, no delivery of the acked word; next fetch address = branch_addr.
5. PC at 10'h3FF → next fetched address 10'h000.
6. halt asserted with a request outstanding → the ack is still pushed, no further mem_req until halt=0; reset asserted mid-request → all outputs return to their reset values at the next edge, and a late ack is ignored.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared widths and state encoding for the fetch stage
package inst_fetch_pkg;

  localparam int INST_LEN = 16;
  localparam int PC_LEN   = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_fifo.sv
// rtl/inst_fetch_fifo.sv - 2-entry shift FIFO; the head register holds its value when empty
module fetch_fifo #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       count_q;
  logic             pop_ok;

  assign pop_ok   = pop && (count_q != 2'd0);
  assign data_out = head_q;
  assign count    = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else if (clear) begin
      count_q <= 2'd0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (count_q == 2'd0) head_q <= data_in;
          else                 tail_q <= data_in;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          // Popping the last word leaves head_q untouched so the output holds.
          if (count_q == 2'd2) head_q <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= data_in;
          end else begin
            head_q <= tail_q;
            tail_q <= data_in;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !clear) begin
      assert (!(push && !pop_ok && count_q == 2'd2));
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - program counter, single-outstanding memory read and prefetch buffer
module inst_fetch #(
  parameter int INST_LEN     = inst_fetch_pkg::INST_LEN,
  parameter int PC_LEN       = inst_fetch_pkg::PC_LEN,
  parameter int RESET_VECTOR = 0
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_LEN-1:0]   mem_addr,
  output logic                mem_req,
  input  logic [INST_LEN-1:0] mem_data,
  input  logic                mem_ack,
  input  logic                branch_en,
  input  logic [PC_LEN-1:0]   branch_addr,
  input  logic                halt,
  output logic [INST_LEN-1:0] inst_out,
  output logic [PC_LEN-1:0]   inst_pc,
  output logic                inst_valid,
  input  logic                inst_ready
);

  import inst_fetch_pkg::*;

  fetch_state_t               state_q, state_d;
  logic [PC_LEN-1:0]          pc_q, pc_d;
  logic [PC_LEN-1:0]          addr_q, addr_d;
  logic                       req_q, req_d;
  logic                       ack, push, pop, clear;
  logic [1:0]                 count;
  logic [INST_LEN+PC_LEN-1:0] head;

  assign ack        = mem_ack && req_q && (state_q != IDLE);
  assign pop        = inst_valid && inst_ready && !branch_en;
  assign inst_valid = (count != 2'd0);
  assign {inst_out, inst_pc} = head;
  assign mem_req    = req_q;
  assign mem_addr   = addr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= PC_LEN'(RESET_VECTOR);
      addr_q  <= PC_LEN'(RESET_VECTOR);
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    push    = 1'b0;
    clear   = 1'b0;
    if (ack) req_d = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;

      FETCH, HALT: begin
        if (branch_en) begin
          // The acked word (if any) is dropped; a still-pending read must be drained.
          clear   = 1'b1;
          pc_d    = branch_addr;
          if (req_q && !mem_ack) state_d = FLUSH;
          else                   state_d = state_q;
        end else begin
          if (ack) begin
            push = 1'b1;
            pc_d = pc_q + 1'b1;
          end
          if (state_q == HALT) begin
            if (!halt) state_d = FETCH;
          end else if (halt) begin
            state_d = HALT;
          end else if (!req_q && count != 2'd2) begin
            req_d  = 1'b1;
            addr_d = pc_q;
          end
        end
      end

      FLUSH: begin
        if (branch_en) begin
          clear = 1'b1;
          pc_d  = branch_addr;
        end
        if (ack) state_d = FETCH;
      end
    endcase
  end

  fetch_fifo #(
    .WIDTH (INST_LEN + PC_LEN)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .clear    (clear),
    .data_in  ({mem_data, addr_q}),
    .data_out (head),
    .count    (count)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch with a grant-limited memory model
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  mem_addr;
  logic        mem_req;
  logic [15:0] mem_data = 16'h0;
  logic        mem_ack = 1'b0;
  logic        branch_en = 1'b0;
  logic [9:0]  branch_addr = 10'h0;
  logic        halt = 1'b0;
  logic [15:0] inst_out;
  logic [9:0]  inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b1;

  typedef struct packed {
    logic [9:0]  pc;
    logic [15:0] inst;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   grant_total = 0;
  int   grant_used = 0;
  int   force_req = 0;
  int   force_done = 0;
  int   ack_delay = 1;
  int   cnt = 0;

  always #5 clk = ~clk;

  inst_fetch #(
    .INST_LEN     (16),
    .PC_LEN       (10),
    .RESET_VECTOR (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .mem_data    (mem_data),
    .mem_ack     (mem_ack),
    .branch_en   (branch_en),
    .branch_addr (branch_addr),
    .halt        (halt),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready)
  );

  // Memory answers only while grants remain; forced acks model a stray late response.
  always @(posedge clk) begin
    #1;
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (force_done != force_req) begin
      force_done++;
      mem_ack  = 1'b1;
      mem_data = 16'hDEAD;
    end else if (reset) begin
      cnt = 0;
    end else if (mem_req && grant_used < grant_total) begin
      if (cnt >= ack_delay) begin
        mem_ack  = 1'b1;
        mem_data = 16'hA000 + {6'd0, mem_addr};
        grant_used++;
        cnt = 0;
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic expect_word(input logic [9:0] pc, input logic [15:0] inst);
    exp_t e;
    e.pc   = pc;
    e.inst = inst;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_req(input logic lvl, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (mem_req !== lvl && n < 40);
  endtask

  task automatic run_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && inst_valid && inst_ready && !branch_en) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_delivery got pc=%h inst=%h expected none", inst_pc, inst_out);
        end else begin
          e = sb.pop_front();
          check("deliver_pc", {22'd0, inst_pc}, {22'd0, e.pc});
          check("deliver_inst", {16'd0, inst_out}, {16'd0, e.inst});
        end
      end
    end
  endtask

  task automatic run_watchdog();
    repeat (3000) @(posedge clk);
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "bench timeout");
  endtask

  initial begin
    int n;
    int hi;
    fork
      run_monitor();
      run_watchdog();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst_out", inst_out, 0);
    check("rst_inst_pc", inst_pc, 0);

    // Sequential fetch with immediate acks
    ack_delay = 1;
    expect_word(10'h000, 16'hA000);
    expect_word(10'h001, 16'hA001);
    expect_word(10'h002, 16'hA002);
    grant_total = 3;
    @(posedge clk);
    #1 reset = 1'b0;
    wait_req(1'b1, n);
    check("first_req_latency", n, 2);
    check("first_req_addr", mem_addr, 10'h000);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!inst_valid && n < 20);
    check("first_valid_latency", n, 2);
    tick(12);
    check("t1_drained", sb.size(), 0);

    // Backpressure: exactly two words buffered, then no new request
    inst_ready = 1'b0;
    expect_word(10'h003, 16'hA003);
    expect_word(10'h004, 16'hA004);
    grant_total += 2;
    tick(12);
    check("t2_no_req_when_full", mem_req, 0);
    check("t2_valid_held", inst_valid, 1);
    check("t2_head_pc", inst_pc, 10'h003);
    inst_ready = 1'b1;
    tick(8);
    check("t2_drained", sb.size(), 0);

    // Branch while the read to 5 is outstanding; its ack must be discarded
    check("t3_pending_req", mem_req, 1);
    check("t3_pending_addr", mem_addr, 10'h005);
    ack_delay   = 3;
    grant_total += 1;
    branch_en   = 1'b1;
    branch_addr = 10'h3F0;
    tick(1);
    branch_en = 1'b0;
    check("t3_flush_req_held", mem_req, 1);
    check("t3_flush_addr_held", mem_addr, 10'h005);
    expect_word(10'h3F0, 16'hA3F0);
    expect_word(10'h3F1, 16'hA3F1);
    grant_total += 2;
    tick(30);
    check("t3_drained", sb.size(), 0);
    ack_delay = 1;

    // Branch, ack and a ready pop all in one cycle
    inst_ready = 1'b0;
    grant_total += 1;
    tick(8);
    check("t4_head_pc", inst_pc, 10'h3F2);
    grant_total += 1;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!mem_ack && n < 20);
    check("t4_ack_seen", mem_ack, 1);
    branch_en   = 1'b1;
    branch_addr = 10'h3FE;
    inst_ready  = 1'b1;
    @(posedge clk);
    #1 branch_en = 1'b0;
    check("t4_fifo_cleared", inst_valid, 0);
    check("t4_req_dropped", mem_req, 0);
    wait_req(1'b1, n);
    check("t4_target_latency", n, 1);
    check("t4_target_addr", mem_addr, 10'h3FE);

    // PC wrap from 3FF to 000
    expect_word(10'h3FE, 16'hA3FE);
    expect_word(10'h3FF, 16'hA3FF);
    expect_word(10'h000, 16'hA000);
    expect_word(10'h001, 16'hA001);
    grant_total += 4;
    tick(16);
    check("t5_drained", sb.size(), 0);
    check("t5_wrapped_req", mem_req, 1);
    check("t5_wrapped_addr", mem_addr, 10'h002);

    // Halt with a request outstanding
    halt = 1'b1;
    expect_word(10'h002, 16'hA002);
    grant_total += 1;
    wait_req(1'b0, n);
    check("t6_ack_completes", mem_req, 0);
    hi = 0;
    repeat (8) begin
      tick(1);
      if (mem_req) hi++;
    end
    check("t6_no_req_in_halt", hi, 0);
    check("t6_drained", sb.size(), 0);
    halt = 1'b0;
    wait_req(1'b1, n);
    check("t6_resume_addr", mem_addr, 10'h003);

    // Reset mid-request, then a stray ack while in IDLE
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #2 force_req++;
    @(negedge clk);
    check("rst2_mem_req", mem_req, 0);
    check("rst2_mem_addr", mem_addr, 0);
    check("rst2_inst_valid", inst_valid, 0);
    check("rst2_inst_out", inst_out, 0);
    check("rst2_inst_pc", inst_pc, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_req(1'b1, n);
    check("rst2_req_latency", n, 2);
    check("rst2_req_addr", mem_addr, 10'h000);
    check("rst2_late_ack_ignored", inst_valid, 0);
    expect_word(10'h000, 16'hA000);
    grant_total += 1;
    tick(8);
    check("rst2_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
